axis_frame_arbiter: RTL and testbench
=====================================

AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, the number of AXI-stream source ports (2..8).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, the tdata width per port.
REQ-003 The block SHALL have parameter ID_BITS, default 2, the grant index width, equal to clog2(NUM_SRC).
REQ-004 The block SHALL have port clk_i, input, width 1: the single clock, with all logic on its rising edge.
REQ-005 The block SHALL have port rst_i, input, width 1: reset, synchronous, active-high.
REQ-006 The block SHALL have port axis_s_data_i, input, width NUM_SRC*DATA_BITS: source data, with source k at bits [k*DATA_BITS +: DATA_BITS].
REQ-007 The block SHALL have ports axis_s_valid_i (input), axis_s_last_i (input) and axis_s_ready_o (output), each width NUM_SRC: per-source handshake and frame end.
REQ-008 The block SHALL have ports axis_m_data_o (output, DATA_BITS), axis_m_valid_o (output, 1), axis_m_ready_i (input, 1) and axis_m_last_o (output, 1): the merged stream.
REQ-009 The block SHALL have port axis_m_id_o, output, width ID_BITS: index of the granted source.
REQ-010 The block SHALL have port busy_o, output, width 1: high while a frame is granted.
REQ-011 The block SHALL have ports frame_cnt_o (output, NUM_SRC*16), completed frames per source, and beat_cnt_o (output, 16), beats in the current frame.

Function
REQ-012 The block SHALL use an FSM with states IDLE and XFER.
REQ-013 In IDLE with any axis_s_valid_i bit high, the block SHALL select the first asserted source at or after rr_ptr (cyclic search), register it as grant, and enter XFER on the next edge.
REQ-014 In IDLE, all axis_s_ready_o bits, axis_m_valid_o and axis_m_last_o SHALL be 0, giving a one-cycle arbitration bubble per frame.
REQ-015 In XFER, axis_m_data_o, axis_m_valid_o and axis_m_last_o SHALL combinationally follow source grant, and axis_s_ready_o[grant] SHALL equal axis_m_ready_i.
REQ-016 In XFER, every non-granted axis_s_ready_o bit SHALL be 0.
REQ-017 A beat SHALL transfer only when axis_m_valid_o and axis_m_ready_i are both 1 in the same cycle.
REQ-018 The grant SHALL be held from the first beat to the last beat of a frame, including cycles where the granted valid is low; a frame is never interleaved.
REQ-019 On a transfer with axis_s_last_i[grant]=1, the block SHALL return to IDLE and set rr_ptr to (grant+1) mod NUM_SRC.
REQ-020 A single-beat frame (last on the first beat) SHALL be legal and SHALL take 2 cycles minimum, IDLE plus XFER.
REQ-021 Requests arriving or dropping during XFER SHALL NOT affect the current grant; arbitration happens only in IDLE.
REQ-022 A source that deasserts valid in IDLE before it is granted SHALL simply not be selected; no request latching is performed.
REQ-023 axis_m_id_o SHALL show grant in XFER and 0 in IDLE.
REQ-024 busy_o SHALL be 1 exactly when the state is XFER.

Reset
REQ-025 While rst_i=1 at a clock edge, the block SHALL set state=IDLE, grant=0 and rr_ptr=0.
REQ-026 Reset SHALL clear all counters to 0.
REQ-027 During and after reset, all outputs SHALL be 0 until the next arbitration.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no flush and no completing last; the next grant after reset SHALL start from source 0.

Configuration
REQ-029 When macro AXIS_FRAME_ARBITER_STATS_EN is defined, frame_cnt_o[k] SHALL increment on each last-beat transfer of source k, saturating at 0xFFFF.
REQ-030 When AXIS_FRAME_ARBITER_STATS_EN is defined, beat_cnt_o SHALL increment on each transfer, saturating at 0xFFFF, and clear to 0 on the cycle after a last-beat transfer.
REQ-031 When AXIS_FRAME_ARBITER_STATS_EN is undefined, frame_cnt_o and beat_cnt_o SHALL be constant 0 and no counter flops SHALL be built; all other behaviour SHALL be identical.

Verification
REQ-032 Scenario: sources 0..3 all valid, each sending a 3-beat frame, m_ready=1 -> grant order 0,1,2,3; 4 bubbles total; 16 cycles from the first IDLE; every last aligned.
REQ-033 Scenario: rr_ptr=2, with only sources 0 and 3 valid -> source 3 is granted first, then source 0.
REQ-034 Scenario: granted source 1 drops valid for 5 cycles mid-frame while source 2 is valid -> grant stays 1, axis_s_ready_o[2]=0 throughout, and no beat from source 2 appears before source 1's last.
REQ-035 Scenario: axis_m_ready_i toggles 1,0,1,0 during a 4-beat frame with data 0x11..0x14 -> output carries exactly 0x11,0x12,0x13,0x14 in order, with no duplicates and no drops.
REQ-036 Scenario: rst_i pulsed for 1 cycle at beat 2 of a source-2 frame -> next cycle all outputs are 0 and busy_o=0; with all sources valid afterwards, source 0 is granted first.
REQ-037 Scenario (with STATS_EN): source 1 sends two frames of 1 and 5 beats -> frame_cnt_o[1]=2; beat_cnt_o reaches 5 and then clears; without STATS_EN both outputs read 0.

Source files
------------

// File: rtl/axis_frame_arbiter.sv
// -----------------------------------------------------------------------------
// axis_frame_arbiter
//
// Merges NUM_SRC AXI-stream sources onto one output stream, one whole frame at
// a time. Arbitration is round-robin and happens only while idle, so every
// frame costs one bubble cycle before its first beat. Once a source is granted
// it owns the output until its last beat transfers, even if its valid drops.
//
// Ports:
//   clk_i, rst_i           clock and synchronous active-high reset
//   axis_s_data_i          source data, source k at [k*DATA_BITS +: DATA_BITS]
//   axis_s_valid_i/last_i  per-source valid and frame end
//   axis_s_ready_o         per-source ready (only the granted bit can be high)
//   axis_m_*               merged output stream
//   axis_m_id_o            granted source index (0 while idle)
//   busy_o                 high while a frame is granted
//   frame_cnt_o            completed frames per source, 16 bits each
//   beat_cnt_o             beats in the current frame
//
// Build option:
//   AXIS_FRAME_ARBITER_STATS_EN  when defined, builds the saturating frame and
//                                beat counters; otherwise both read 0.
// -----------------------------------------------------------------------------
module axis_frame_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int DATA_BITS = 8,
    parameter int ID_BITS   = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_SRC*DATA_BITS-1:0] axis_s_data_i,
    input  logic [NUM_SRC-1:0]           axis_s_valid_i,
    input  logic [NUM_SRC-1:0]           axis_s_last_i,
    output logic [NUM_SRC-1:0]           axis_s_ready_o,
    output logic [DATA_BITS-1:0]         axis_m_data_o,
    output logic                         axis_m_valid_o,
    input  logic                         axis_m_ready_i,
    output logic                         axis_m_last_o,
    output logic [ID_BITS-1:0]           axis_m_id_o,
    output logic                         busy_o,
    output logic [NUM_SRC*16-1:0]        frame_cnt_o,
    output logic [15:0]                  beat_cnt_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [ID_BITS-1:0]   grant_q, grant_d;
    logic [ID_BITS-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_SRC-1:0]   valid_rot_s;
    logic [ID_BITS:0]     pick_off_s;
    logic [ID_BITS:0]     pick_sum_s;
    logic [ID_BITS-1:0]   pick_idx_s;
    logic [DATA_BITS-1:0] src_data_s [NUM_SRC];
    logic                 xfer_s;
    logic                 last_beat_s;

    // Round-robin pick: rotate the requests so rr_ptr sits at bit 0, take the
    // lowest set bit, then rotate the offset back into a source index.
    always_comb begin
        valid_rot_s = NUM_SRC'({axis_s_valid_i, axis_s_valid_i} >> rr_ptr_q);
        pick_off_s  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (valid_rot_s[i]) begin
                pick_off_s = (ID_BITS+1)'(i);
            end else begin
                pick_off_s = pick_off_s;
            end
        end
        pick_sum_s = {1'b0, rr_ptr_q} + pick_off_s;
        if (pick_sum_s >= (ID_BITS+1)'(NUM_SRC)) begin
            pick_idx_s = ID_BITS'(pick_sum_s - (ID_BITS+1)'(NUM_SRC));
        end else begin
            pick_idx_s = pick_sum_s[ID_BITS-1:0];
        end
    end

    // Unpack the flat source data bus into one word per source.
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            src_data_s[k] = axis_s_data_i[k*DATA_BITS +: DATA_BITS];
        end
    end

    // Output steering: everything is quiet in IDLE; in XFER the granted source
    // is wired straight through and only its ready may rise.
    always_comb begin
        axis_m_data_o  = '0;
        axis_m_valid_o = 1'b0;
        axis_m_last_o  = 1'b0;
        axis_s_ready_o = '0;
        axis_m_id_o    = '0;
        busy_o         = 1'b0;
        if (state_q == ST_XFER) begin
            axis_m_data_o           = src_data_s[grant_q];
            axis_m_valid_o          = axis_s_valid_i[grant_q];
            axis_m_last_o           = axis_s_last_i[grant_q];
            axis_s_ready_o[grant_q] = axis_m_ready_i;
            axis_m_id_o             = grant_q;
            busy_o                  = 1'b1;
        end else begin
            busy_o = 1'b0;
        end
    end

    assign xfer_s      = axis_m_valid_o & axis_m_ready_i;
    assign last_beat_s = xfer_s & axis_m_last_o;

    // Next-state logic: arbitrate only in IDLE, release only on the last beat.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|axis_s_valid_i) begin
                    state_d = ST_XFER;
                    grant_d = pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (last_beat_s) begin
                    state_d = ST_IDLE;
                    if (grant_q == ID_BITS'(NUM_SRC - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_q + ID_BITS'(1);
                    end
                end else begin
                    state_d = ST_XFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef AXIS_FRAME_ARBITER_STATS_EN
    logic [NUM_SRC-1:0][15:0] frame_cnt_q;
    logic [15:0]              beat_cnt_q;
    logic                     beat_clr_q;

    // Saturating statistics. The beat count keeps the final frame length
    // visible for one cycle after the last beat, then clears.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_cnt_q <= '0;
            beat_cnt_q  <= 16'd0;
            beat_clr_q  <= 1'b0;
        end else begin
            beat_clr_q <= last_beat_s;
            if (beat_clr_q) begin
                beat_cnt_q <= 16'd0;
            end else if (xfer_s && (beat_cnt_q != 16'hFFFF)) begin
                beat_cnt_q <= beat_cnt_q + 16'd1;
            end else begin
                beat_cnt_q <= beat_cnt_q;
            end
            for (int k = 0; k < NUM_SRC; k++) begin
                if (last_beat_s && (grant_q == ID_BITS'(k)) && (frame_cnt_q[k] != 16'hFFFF)) begin
                    frame_cnt_q[k] <= frame_cnt_q[k] + 16'd1;
                end else begin
                    frame_cnt_q[k] <= frame_cnt_q[k];
                end
            end
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign beat_cnt_o  = beat_cnt_q;
`else
    assign frame_cnt_o = '0;
    assign beat_cnt_o  = 16'd0;
`endif

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for axis_frame_arbiter (NUM_SRC=4, DATA_BITS=8).
// A frame-level reference model predicts every output each cycle; directed
// scenarios add hand-computed expectations on grant order, data and counters.
// -----------------------------------------------------------------------------
module tb_axis_frame_arbiter;

    localparam int NS = 4;
    localparam int DB = 8;
    localparam int IB = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NS*DB-1:0]  s_data = '0;
    logic [NS-1:0]     s_valid = '0;
    logic [NS-1:0]     s_last = '0;
    logic [NS-1:0]     s_ready;
    logic [DB-1:0]     m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              m_last;
    logic [IB-1:0]     m_id;
    logic              busy;
    logic [NS*16-1:0]  frame_cnt;
    logic [15:0]       beat_cnt;

    axis_frame_arbiter #(.NUM_SRC(NS), .DATA_BITS(DB), .ID_BITS(IB)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .axis_s_data_i  (s_data),
        .axis_s_valid_i (s_valid),
        .axis_s_last_i  (s_last),
        .axis_s_ready_o (s_ready),
        .axis_m_data_o  (m_data),
        .axis_m_valid_o (m_valid),
        .axis_m_ready_i (m_ready),
        .axis_m_last_o  (m_last),
        .axis_m_id_o    (m_id),
        .busy_o         (busy),
        .frame_cnt_o    (frame_cnt),
        .beat_cnt_o     (beat_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int cur = -1;          // owner of the output, -1 when idle
    int rr = 0;            // next source to be considered first
    int fcnt[NS];
    int bcnt = 0;
    bit clr_pend = 1'b0;
    int cap_id[$];
    int cap_data[$];
    int cap_last[$];

    logic [DB-1:0]    e_data;
    logic             e_valid, e_last, e_busy;
    logic [NS-1:0]    e_ready;
    logic [IB-1:0]    e_id;
    logic [NS*16-1:0] e_frame;
    logic [15:0]      e_beat;

    initial begin
        for (int k = 0; k < NS; k++) fcnt[k] = 0;
    end

    // Compare every output against the model, then advance the model by one edge.
    always @(negedge clk) begin
        if (cur < 0) begin
            e_data = '0; e_valid = 1'b0; e_last = 1'b0;
            e_ready = '0; e_id = '0; e_busy = 1'b0;
        end else begin
            e_data  = s_data[cur*DB +: DB];
            e_valid = s_valid[cur];
            e_last  = s_last[cur];
            e_ready = m_ready ? (NS'(1) << cur) : '0;
            e_id    = IB'(cur);
            e_busy  = 1'b1;
        end
`ifdef AXIS_FRAME_ARBITER_STATS_EN
        for (int k = 0; k < NS; k++) e_frame[k*16 +: 16] = 16'(fcnt[k]);
        e_beat = 16'(bcnt);
`else
        e_frame = '0;
        e_beat  = 16'd0;
`endif
        chk("m_data", m_data, e_data);
        chk("m_valid", m_valid, e_valid);
        chk("m_last", m_last, e_last);
        chk("s_ready", s_ready, e_ready);
        chk("m_id", m_id, e_id);
        chk("busy", busy, e_busy);
        chk("frame_cnt", frame_cnt, e_frame);
        chk("beat_cnt", beat_cnt, e_beat);

        if (rst) begin
            cur = -1; rr = 0; bcnt = 0; clr_pend = 1'b0;
            for (int k = 0; k < NS; k++) fcnt[k] = 0;
        end else begin
            if (clr_pend) begin
                bcnt = 0;
                clr_pend = 1'b0;
            end
            if (cur < 0) begin
                for (int i = 0; i < NS; i++)
                    if (cur < 0 && s_valid[(rr + i) % NS]) cur = (rr + i) % NS;
            end else if (s_valid[cur] && m_ready) begin
                if (bcnt < 65535) bcnt++;
                cap_id.push_back(cur);
                cap_data.push_back(int'(s_data[cur*DB +: DB]));
                cap_last.push_back(int'(s_last[cur]));
                if (s_last[cur]) begin
                    if (fcnt[cur] < 65535) fcnt[cur]++;
                    clr_pend = 1'b1;
                    rr = (cur + 1) % NS;
                    cur = -1;
                end
            end
        end
    end

    // ---------------- source drivers ----------------
    int lenq[NS][$];       // pending frame lengths per source
    int bc[NS];            // beat index within current frame
    int sq[NS];            // beats sent so far, seeds the data pattern
    bit en[NS];            // forces valid low when cleared
    bit busy_seen;

    function automatic bit pending();
        bit p = 1'b0;
        for (int k = 0; k < NS; k++) if (lenq[k].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        bit v;
        for (int k = 0; k < NS; k++) begin
            v = en[k] && (lenq[k].size() > 0);
            s_valid[k] = v;
            s_last[k]  = v && (bc[k] == lenq[k][0] - 1);
            s_data[k*DB +: DB] = DB'(k*16 + (sq[k] % 16) + 1);
        end
    endtask

    task automatic clear_sources();
        for (int k = 0; k < NS; k++) begin
            lenq[k].delete(); bc[k] = 0; sq[k] = 0; en[k] = 1'b1;
        end
    endtask

    task automatic clear_cap();
        cap_id.delete(); cap_data.delete(); cap_last.delete();
    endtask

    task automatic tick();
        logic [NS-1:0] hs;
        drive();
        @(negedge clk);
        hs = s_valid & s_ready;
        busy_seen = busy;
        @(posedge clk);
        #1;
        for (int k = 0; k < NS; k++) begin
            if (hs[k]) begin
                sq[k]++;
                if (bc[k] == lenq[k][0] - 1) begin
                    void'(lenq[k].pop_front());
                    bc[k] = 0;
                end else begin
                    bc[k]++;
                end
            end
        end
        drive();
    endtask

    task automatic run(input int budget, output int n, output int bubbles);
        n = 0; bubbles = 0;
        while (pending() && n < budget) begin
            tick();
            n++;
            if (!busy_seen) bubbles++;
        end
        chk("run_timeout", {63'd0, pending()}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, bub;
        int exp_ids[$];
        clear_sources();

        // Reset: everything quiet.
        rst = 1'b1; tick(); tick(); rst = 1'b0; drive();
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_frame_cnt", frame_cnt, 0);

        // Four sources, 3-beat frames, ready high: order 0..3, 16 cycles, 4 bubbles.
        m_ready = 1'b1;
        clear_cap();
        for (int k = 0; k < NS; k++) lenq[k].push_back(3);
        run(100, n, bub);
        chk("rr_cycles", n, 16);
        chk("rr_bubbles", bub, 4);
        chk("rr_beats", cap_id.size(), 12);
        for (int i = 0; i < 12; i++) begin
            chk("rr_id", cap_id[i], i / 3);
            chk("rr_last", cap_last[i], ((i % 3) == 2) ? 1 : 0);
            chk("rr_data", cap_data[i], (i / 3) * 16 + (i % 3) + 1);
        end

        // Move the pointer to 2 with a single-beat frame from source 1,
        // then sources 0 and 3 compete: 3 wins, then 0.
        lenq[1].push_back(1);
        run(10, n, bub);
        chk("single_beat_cycles", n, 2);
        clear_cap();
        lenq[0].push_back(1); lenq[3].push_back(1);
        run(20, n, bub);
        chk("wrap_count", cap_id.size(), 2);
        chk("wrap_first", cap_id[0], 3);
        chk("wrap_second", cap_id[1], 0);

        // Granted source 1 stalls for 5 cycles while source 2 waits.
        clear_cap();
        lenq[1].push_back(4); lenq[2].push_back(2);
        tick(); tick();
        en[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_id", m_id, 1);
            chk("stall_ready2", s_ready[2], 0);
            chk("stall_busy", busy, 1);
        end
        en[1] = 1'b1;
        run(30, n, bub);
        exp_ids = '{1, 1, 1, 1, 2, 2};
        chk("stall_beats", cap_id.size(), 6);
        for (int i = 0; i < 6; i++) chk("stall_order", cap_id[i], exp_ids[i]);
        chk("stall_last1", cap_last[3], 1);

        // Back-pressure toggling on a 4-beat frame from source 1.
        clear_cap();
        sq[1] = 0;
        lenq[1].push_back(4);
        n = 0;
        while (pending() && n < 40) begin
            m_ready = (n % 2) == 0;
            tick();
            n++;
        end
        chk("bp_timeout", {63'd0, pending()}, 64'd0);
        m_ready = 1'b1;
        chk("bp_beats", cap_data.size(), 4);
        for (int i = 0; i < 4; i++) chk("bp_data", cap_data[i], 32'h11 + i);

        // Reset in the middle of a source-2 frame.
        lenq[2].push_back(4);
        tick(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        clear_sources(); drive();
        chk("midrst_busy", busy, 0);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_last", m_last, 0);
        chk("midrst_m_data", m_data, 0);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_id", m_id, 0);
        chk("midrst_beat_cnt", beat_cnt, 0);
        clear_cap();
        for (int k = 0; k < NS; k++) lenq[k].push_back(1);
        run(30, n, bub);
        chk("midrst_first", cap_id[0], 0);

        // Statistics: source 1 sends 1-beat then 5-beat frames.
        rst = 1'b1; tick(); rst = 1'b0;
        clear_sources();
        lenq[1].push_back(1); lenq[1].push_back(5);
        run(30, n, bub);
`ifdef AXIS_FRAME_ARBITER_STATS_EN
        chk("stats_frames", frame_cnt[31:16], 2);
        chk("stats_beats", beat_cnt, 5);
        tick();
        chk("stats_clear", beat_cnt, 0);
`else
        chk("stats_frames", frame_cnt[31:16], 0);
        chk("stats_beats", beat_cnt, 0);
        tick();
        chk("stats_clear", beat_cnt, 0);
`endif
        chk("stats_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
